// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Purpose  : MEM-stage data-memory access sequencer. Turns a load/store held
//             in the EX/MEM register into a single request/ready transaction
//             against a variable-latency data memory. It stalls the front of
//             the pipeline until the access completes, and presents load data
//             with a one-cycle valid pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset            rising-edge clock, synchronous active-high reset
//    memread/memwrite_EX_MEM, alu_result_EX_MEM, read_data2_EX_MEM
//                          access request, address and store data
//    mem_req/mem_we/mem_addr/mem_wdata
//                          registered memory request bus
//    mem_ready/mem_rdata   memory completion and read data
//    stall                 combinational pipeline freeze
//    read_data_MEM/rdata_valid
//                          captured load data and its one-cycle strobe
//    access_err            sticky timeout flag
//  Configuration
//    DMEM_TIMEOUT_EN       when defined, builds a BUSY watchdog that aborts an
//                          access after TIMEOUT_CYCLES cycles without ready
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread_EX_MEM,
    input  logic              memwrite_EX_MEM,
    input  logic [ADDR_W-1:0] alu_result_EX_MEM,
    input  logic [DATA_W-1:0] read_data2_EX_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] read_data_MEM,
    output logic              rdata_valid,
    output logic              access_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_read_data;

    logic              w_access;
    logic              w_timeout;
    logic              w_stall;
    logic              w_rdata_valid;

    assign w_access = memread_EX_MEM | memwrite_EX_MEM;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and combinational outputs. DONE never looks at the request:
    // EX/MEM still holds the finished instruction during DONE and only
    // advances at the end of it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_stall       = 1'b0;
        w_rdata_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (mem_ready || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_rdata_valid = ~r_mem_we;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request bus and load-data capture. A simultaneous read+write request
    // issues as a write because mem_we follows memwrite alone.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= memwrite_EX_MEM;
                        r_mem_addr  <= alu_result_EX_MEM;
                        r_mem_wdata <= read_data2_EX_MEM;
                    end
                end
                ST_BUSY: begin
                    // ready wins over a timeout landing in the same cycle
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_read_data <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_read_data <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_busy_cnt;
    logic               r_access_err;

    // r_busy_cnt holds the number of BUSY cycles already elapsed, so the
    // abort fires in the TIMEOUT_CYCLES-th BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt   <= '0;
            r_access_err <= 1'b0;
        end else begin
            if (r_state == ST_BUSY) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end else begin
                r_busy_cnt <= '0;
            end
            if (w_timeout) begin
                r_access_err <= 1'b1;
            end
        end
    end

    assign w_timeout  = (r_state == ST_BUSY) && !mem_ready && (r_busy_cnt == c_cnt_last);
    assign access_err = r_access_err;
`else
    // The timeout length only matters when the watchdog is built.
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);

    assign w_timeout  = 1'b0;
    assign access_err = 1'b0;
`endif

    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign read_data_MEM = r_read_data;
    assign stall         = w_stall;
    assign rdata_valid   = w_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Purpose  : Self-checking bench for dmem_access_ctrl. Each directed
//             transaction is described by its timeline (issue cycle, ready
//             cycle, done cycle), from which per-cycle expected outputs are
//             derived and compared every cycle, plus literal spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int c_aw  = 32;
    localparam int c_dw  = 32;
    localparam int c_tmo = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            memread;
    logic            memwrite;
    logic [c_aw-1:0] alu;
    logic [c_dw-1:0] rd2;
    logic            mem_req;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic            mem_ready;
    logic [c_dw-1:0] mem_rdata;
    logic            stall;
    logic [c_dw-1:0] read_data_MEM;
    logic            rdata_valid;
    logic            access_err;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W         (c_aw),
        .DATA_W         (c_dw),
        .TIMEOUT_CYCLES (c_tmo)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .memread_EX_MEM    (memread),
        .memwrite_EX_MEM   (memwrite),
        .alu_result_EX_MEM (alu),
        .read_data2_EX_MEM (rd2),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .stall             (stall),
        .read_data_MEM     (read_data_MEM),
        .rdata_valid       (rdata_valid),
        .access_err        (access_err)
    );

    // Model: what the outputs must be in the current cycle
    logic [c_aw-1:0] m_addr;
    logic [c_dw-1:0] m_wdata;
    logic [c_dw-1:0] m_rdata;
    logic            m_we;
    logic            m_err;
    logic            e_req;
    logic            e_stall;
    logic            e_rv;

    bit chk_en   = 1'b0;
    bit prev_req = 1'b0;
    int n_tests  = 0;
    int n_fail   = 0;
    int stall_cnt;
    int rv_cnt;
    int txn_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req",       mem_req,       e_req);
            check("mem_we",        mem_we,        m_we);
            check("mem_addr",      mem_addr,      m_addr);
            check("mem_wdata",     mem_wdata,     m_wdata);
            check("stall",         stall,         e_stall);
            check("rdata_valid",   rdata_valid,   e_rv);
            check("read_data_MEM", read_data_MEM, m_rdata);
            check("access_err",    access_err,    m_err);
            if (stall)                stall_cnt++;
            if (rdata_valid)          rv_cnt++;
            if (mem_req && !prev_req) txn_cnt++;
            prev_req = mem_req;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_we    = 1'b0;
        m_err   = 1'b0;
        e_req   = 1'b0;
        e_stall = 1'b0;
        e_rv    = 1'b0;
    endtask

    task automatic clr_counts;
        stall_cnt = 0;
        rv_cnt    = 0;
        txn_cnt   = 0;
    endtask

    task automatic idle(input logic rdy);
        memread   = 1'b0;
        memwrite  = 1'b0;
        mem_ready = rdy;
        e_req     = 1'b0;
        e_stall   = 1'b0;
        e_rv      = 1'b0;
        tick();
    endtask

    // One transaction: issue cycle, k BUSY cycles with ready in the k-th,
    // then DONE. k == 0 means ready never comes (watchdog abort).
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k, input logic [31:0] rdata);
        int last;
        last = (k == 0) ? c_tmo : k;
        memread   = rd;
        memwrite  = wr;
        alu       = addr;
        rd2       = wdata;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        e_req     = 1'b0;
        e_stall   = 1'b1;
        e_rv      = 1'b0;
        tick();
        m_addr  = addr;
        m_wdata = wdata;
        m_we    = wr;
        for (int i = 1; i <= last; i++) begin
            alu       = ~addr;
            rd2       = ~wdata;
            mem_ready = (k == i);
            mem_rdata = (k == i) ? rdata : (32'hBAD0_0000 + i);
            e_req     = 1'b1;
            e_stall   = 1'b1;
            e_rv      = 1'b0;
            tick();
        end
        alu       = addr;
        rd2       = wdata;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        e_req     = 1'b0;
        e_stall   = 1'b0;
        e_rv      = !wr;
        if (k == 0) begin
            m_rdata = '0;
            m_err   = 1'b1;
        end else if (!wr) begin
            m_rdata = rdata;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        alu       = '0;
        rd2       = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        model_reset();
        clr_counts();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        idle(1'b1);
        idle(1'b0);

        // Single-cycle-latency load
        clr_counts();
        access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
        check("load_stall_cycles", stall_cnt, 2);
        check("load_rv_pulses", rv_cnt, 1);
        check("load_data", read_data_MEM, 32'hDEADBEEF);
        idle(1'b0);

        // Store with ready after 4 BUSY cycles
        clr_counts();
        access(1'b0, 1'b1, 32'h20, 32'h12345678, 4, 32'hFFFF0000);
        check("store_stall_cycles", stall_cnt, 5);
        check("store_rv_pulses", rv_cnt, 0);
        check("store_keeps_rdata", read_data_MEM, 32'hDEADBEEF);
        check("store_we", mem_we, 1);
        idle(1'b0);

        // Back-to-back loads
        clr_counts();
        access(1'b1, 1'b0, 32'h30, 32'h0, 1, 32'hA5A50001);
        access(1'b1, 1'b0, 32'h34, 32'h0, 2, 32'h5A5A0002);
        check("b2b_transactions", txn_cnt, 2);
        check("b2b_stall_cycles", stall_cnt, 5);
        check("b2b_rv_pulses", rv_cnt, 2);
        check("b2b_last_data", read_data_MEM, 32'h5A5A0002);
        idle(1'b0);

        // Read and write together issue as a write
        access(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 2, 32'h11111111);
        check("rw_is_write", mem_we, 1);
        check("rw_keeps_rdata", read_data_MEM, 32'h5A5A0002);
        idle(1'b0);

        // Reset during BUSY; a later ready must be ignored
        memread   = 1'b1;
        memwrite  = 1'b0;
        alu       = 32'h50;
        rd2       = 32'h99;
        mem_ready = 1'b0;
        e_req     = 1'b0;
        e_stall   = 1'b1;
        e_rv      = 1'b0;
        tick();
        m_addr  = 32'h50;
        m_wdata = 32'h99;
        m_we    = 1'b0;
        e_req   = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        memread   = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h77777777;
        model_reset();
        tick();
        check("rst_busy_req", mem_req, 0);
        check("rst_busy_addr", mem_addr, 0);
        tick();
        idle(1'b0);
        check("rst_ignored_ready", read_data_MEM, 0);

`ifdef DMEM_TIMEOUT_EN
        // Ready arriving in the timeout cycle completes normally
        access(1'b1, 1'b0, 32'h60, 32'h0, c_tmo, 32'h0BADCAFE);
        check("tmo_edge_err", access_err, 0);
        check("tmo_edge_data", read_data_MEM, 32'h0BADCAFE);
        idle(1'b0);

        // Ready never arrives: abort after 16 BUSY cycles
        clr_counts();
        access(1'b1, 1'b0, 32'h64, 32'h0, 0, 32'h0);
        check("tmo_stall_cycles", stall_cnt, 17);
        check("tmo_data", read_data_MEM, 0);
        check("tmo_err", access_err, 1);
        repeat (3) idle(1'b0);
        check("tmo_err_sticky", access_err, 1);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        model_reset();
        idle(1'b0);
        check("tmo_err_cleared", access_err, 0);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
